// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Arbitrates the single register-file write port between the ALU pipeline
// writeback and results returning from a multi-cycle unit (mul/div/load).
// MDU results are buffered in a 2-entry FIFO.  The ALU normally has priority,
// but a queued MDU result can only be bypassed MAX_WAIT times before the
// arbiter enters FORCE for one cycle, stalls the ALU and issues the FIFO head.
//
// Ports
//   iCLK, iRST        clock, asynchronous active-high reset
//   iAluValid/Rd/Data ALU writeback request
//   oAluStall         ALU request not accepted this cycle (ALU holds it)
//   iMduValid/Rd/Data MDU result, accepted when iMduValid && oMduReady
//   oMduReady         FIFO has room (and not in reset)
//   oRegWrite         registered write enable (rd=0 writes are suppressed)
//   oWriteRegister    registered write address (holds when no write)
//   oWriteData        registered write data    (holds when no write)
//   oMduPending       bit n set while an MDU write to xn is still queued
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iAluValid,
    input  logic [4:0]  iAluRd,
    input  logic [31:0] iAluData,
    output logic        oAluStall,
    input  logic        iMduValid,
    input  logic [4:0]  iMduRd,
    input  logic [31:0] iMduData,
    output logic        oMduReady,
    output logic        oRegWrite,
    output logic [4:0]  oWriteRegister,
    output logic [31:0] oWriteData,
    output logic [31:0] oMduPending
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // FIFO storage and bookkeeping
    logic [4:0]  r_fifo_rd   [2];
    logic [31:0] r_fifo_data [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        w_wr_ptr;

    logic [3:0]  r_wait;
    logic [3:0]  w_wait_next;

    logic        w_push;
    logic        w_pop;
    logic        w_grant_alu;
    logic        w_grant_fifo;
    logic        w_grant;
    logic [4:0]  w_sel_rd;
    logic [31:0] w_sel_data;
    logic        w_do_write;

    logic [31:0] w_pend_entry [2];

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign oMduReady = !iRST && (r_count != 2'd2);
    assign w_push    = iMduValid && oMduReady;
    // Next free slot: head when empty, the other slot when one entry held.
    assign w_wr_ptr  = r_head ^ r_count[0];

    // ------------------------------------------------------------------
    // Grant / next-state / wait counter
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_alu  = 1'b0;
        w_grant_fifo = 1'b0;
        oAluStall    = 1'b0;
        w_state_next = r_state;
        w_wait_next  = r_wait;

        case (r_state)
            ST_NORMAL: begin
                if (iAluValid) begin
                    w_grant_alu = 1'b1;
                end else if (r_count != 2'd0) begin
                    w_grant_fifo = 1'b1;
                end
            end
            ST_FORCE: begin
                w_grant_fifo = (r_count != 2'd0);
                oAluStall    = iAluValid;
                w_state_next = ST_NORMAL;
            end
            default: begin
                w_state_next = ST_NORMAL;
            end
        endcase

        // Counter tracks how many times the current head has been bypassed.
        if (w_grant_fifo || (r_count == 2'd0)) begin
            w_wait_next = 4'd0;
        end else if (r_wait < LP_MAX_WAIT) begin
            w_wait_next = r_wait + 4'd1;
        end

        // Enter FORCE as soon as the bypass count reaches the limit, so the
        // head is issued in the very next cycle (exactly MAX_WAIT bypasses).
        if ((r_state == ST_NORMAL) && (r_count != 2'd0) && !w_grant_fifo &&
            (w_wait_next >= LP_MAX_WAIT)) begin
            w_state_next = ST_FORCE;
        end
    end

    assign w_pop      = w_grant_fifo;
    assign w_grant    = w_grant_alu || w_grant_fifo;
    assign w_sel_rd   = w_grant_alu ? iAluRd   : r_fifo_rd[r_head];
    assign w_sel_data = w_grant_alu ? iAluData : r_fifo_data[r_head];
    // rd=0 requests are consumed but never reach the register file.
    assign w_do_write = w_grant && (w_sel_rd != 5'd0);

    // ------------------------------------------------------------------
    // State, counter, FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= ST_NORMAL;
            r_wait  <= 4'd0;
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    // FIFO payload needs no reset: validity is carried by r_count.
    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_fifo_rd[w_wr_ptr]   <= iMduRd;
            r_fifo_data[w_wr_ptr] <= iMduData;
        end
    end

    // ------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oRegWrite      <= 1'b0;
            oWriteRegister <= 5'd0;
            oWriteData     <= 32'd0;
        end else begin
            oRegWrite <= w_do_write;
            if (w_do_write) begin
                oWriteRegister <= w_sel_rd;
                oWriteData     <= w_sel_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard: one-hot rd of each valid entry, x0 excluded.
    // Entry gi is the gi-th oldest, valid when more than gi entries held.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pend
            logic       w_valid;
            logic [4:0] w_rd;
            assign w_valid = (r_count > 2'(gi));
            assign w_rd    = r_fifo_rd[r_head ^ 1'(gi)];
            assign w_pend_entry[gi] = (w_valid && (w_rd != 5'd0)) ?
                                      (32'd1 << w_rd) : 32'd0;
        end
    endgenerate

    assign oMduPending = w_pend_entry[0] | w_pend_entry[1];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iAluValid;
    logic [4:0]  iAluRd;
    logic [31:0] iAluData;
    logic        oAluStall;
    logic        iMduValid;
    logic [4:0]  iMduRd;
    logic [31:0] iMduData;
    logic        oMduReady;
    logic        oRegWrite;
    logic [4:0]  oWriteRegister;
    logic [31:0] oWriteData;
    logic [31:0] oMduPending;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    regfile_wb_arbiter #(.MAX_WAIT(4)) dut (
        .iCLK           (iCLK),
        .iRST           (iRST),
        .iAluValid      (iAluValid),
        .iAluRd         (iAluRd),
        .iAluData       (iAluData),
        .oAluStall      (oAluStall),
        .iMduValid      (iMduValid),
        .iMduRd         (iMduRd),
        .iMduData       (iMduData),
        .oMduReady      (oMduReady),
        .oRegWrite      (oRegWrite),
        .oWriteRegister (oWriteRegister),
        .oWriteData     (oWriteData),
        .oMduPending    (oMduPending)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic exp_push(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Compare any write on the port against the scoreboard head.
    task automatic check_wb();
        wr_t e;
        if (oRegWrite === 1'b1) begin
            $display("WB x%0d <= %h", oWriteRegister, oWriteData);
            chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wb_rd", 32'(oWriteRegister), 32'(e.rd));
                chk("wb_data", oWriteData, e.data);
            end
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
        check_wb();
    endtask

    initial begin
        int k;
        iRST = 1'b1;
        iAluValid = 1'b1; iAluRd = 5'd3; iAluData = 32'h0;
        iMduValid = 1'b0; iMduRd = 5'd0; iMduData = 32'h0;
        repeat (2) @(posedge iCLK);
        #1;
        // Reset state
        chk("rst_regwrite", 32'(oRegWrite), 32'd0);
        chk("rst_wreg", 32'(oWriteRegister), 32'd0);
        chk("rst_wdata", oWriteData, 32'd0);
        chk("rst_ready", 32'(oMduReady), 32'd0);
        chk("rst_stall", 32'(oAluStall), 32'd0);
        chk("rst_pending", oMduPending, 32'd0);
        iAluValid = 1'b0;
        iRST = 1'b0;
        tick();

        // ALU only
        iAluValid = 1'b1; iAluRd = 5'd5; iAluData = 32'hDEADBEEF;
        #1;
        chk("alu_stall", 32'(oAluStall), 32'd0);
        exp_push(5'd5, 32'hDEADBEEF);
        tick();
        chk("alu_regwrite", 32'(oRegWrite), 32'd1);
        iAluValid = 1'b0;
        tick();
        chk("idle_regwrite", 32'(oRegWrite), 32'd0);

        // MDU only
        iMduValid = 1'b1; iMduRd = 5'd7; iMduData = 32'h12345678;
        #1;
        chk("mdu_ready", 32'(oMduReady), 32'd1);
        exp_push(5'd7, 32'h12345678);
        tick();
        iMduValid = 1'b0;
        chk("mdu_pending_set", oMduPending, 32'h0000_0080);
        chk("mdu_no_early_write", 32'(oRegWrite), 32'd0);
        tick();
        chk("mdu_regwrite", 32'(oRegWrite), 32'd1);
        chk("mdu_pending_clr", oMduPending, 32'd0);

        // x0: ALU and MDU requests to rd=0 are consumed without a write
        iAluValid = 1'b1; iAluRd = 5'd0; iAluData = 32'hBAD0BAD0;
        tick();
        chk("alu_x0_regwrite", 32'(oRegWrite), 32'd0);
        iAluValid = 1'b0;
        iMduValid = 1'b1; iMduRd = 5'd0; iMduData = 32'hBAD1BAD1;
        tick();
        iMduValid = 1'b0;
        chk("mdu_x0_pending", oMduPending, 32'd0);
        tick();
        chk("mdu_x0_regwrite", 32'(oRegWrite), 32'd0);
        iMduValid = 1'b1; iMduRd = 5'd13; iMduData = 32'h0000_0D0D;
        exp_push(5'd13, 32'h0000_0D0D);
        tick();
        iMduValid = 1'b0;
        chk("mdu_after_x0_pending", oMduPending, 32'h0000_2000);
        tick();
        chk("mdu_after_x0_write", 32'(oRegWrite), 32'd1);

        // Reset mid-operation with two queued entries
        iAluValid = 1'b1; iAluRd = 5'd20; iAluData = 32'h2020_2020;
        iMduValid = 1'b1; iMduRd = 5'd21; iMduData = 32'h2121_2121;
        exp_push(5'd20, 32'h2020_2020);
        tick();
        iAluRd = 5'd22; iAluData = 32'h2222_2222;
        iMduRd = 5'd23; iMduData = 32'h2323_2323;
        exp_push(5'd22, 32'h2222_2222);
        tick();
        chk("pre_rst_pending", oMduPending, 32'h00A0_0000);
        iRST = 1'b1;
        #1;
        chk("midrst_regwrite", 32'(oRegWrite), 32'd0);
        chk("midrst_pending", oMduPending, 32'd0);
        chk("midrst_ready", 32'(oMduReady), 32'd0);
        chk("midrst_stall", 32'(oAluStall), 32'd0);
        chk("midrst_wdata", oWriteData, 32'd0);
        tick();
        iRST = 1'b0;
        iMduValid = 1'b0;
        iAluRd = 5'd24; iAluData = 32'h2424_2424;
        exp_push(5'd24, 32'h2424_2424);
        tick();
        chk("post_rst_first_grant", 32'(oRegWrite), 32'd1);
        iAluValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_write", 32'(oRegWrite), 32'd0);
        end
        chk("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

        // Starvation: ALU continuous, one MDU entry queued at c0
        k = 0;
        for (int c = 0; c < 7; c++) begin
            iAluValid = 1'b1;
            iAluRd    = 5'(16 + k);
            iAluData  = 32'hA000_0000 + 32'(k);
            if (c == 0) begin
                iMduValid = 1'b1; iMduRd = 5'd9; iMduData = 32'h9999_0009;
            end else begin
                iMduValid = 1'b0;
            end
            #1;
            chk($sformatf("starve_stall_c%0d", c), 32'(oAluStall), 32'(c == 5));
            if (c == 3) chk("starve_pending", oMduPending, 32'h0000_0200);
            if (c == 5) begin
                exp_push(5'd9, 32'h9999_0009);
            end else begin
                exp_push(5'(16 + k), 32'hA000_0000 + 32'(k));
                k++;
            end
            tick();
        end
        iAluValid = 1'b0;
        tick();
        chk("starve_sb_empty", 32'(exp_q.size()), 32'd0);

        // FIFO full: ALU busy c0..c2, MDU presents three values
        for (int c = 0; c < 6; c++) begin
            iAluValid = (c < 3);
            iAluRd    = 5'(25 + c);
            iAluData  = 32'hB000_0000 + 32'(c);
            iMduValid = (c < 5);
            iMduRd    = (c == 0) ? 5'd10 : (c == 1) ? 5'd11 : 5'd12;
            iMduData  = (c == 0) ? 32'h1010_1010 : (c == 1) ? 32'h1111_1111 : 32'h1212_1212;
            #1;
            if (c < 5) chk($sformatf("full_ready_c%0d", c), 32'(oMduReady), 32'(c != 2 && c != 3));
            if (c == 3) chk("full_pending", oMduPending, 32'h0000_0C00);
            if (c < 3) exp_push(5'(25 + c), 32'hB000_0000 + 32'(c));
            if (c == 3) exp_push(5'd10, 32'h1010_1010);
            if (c == 4) exp_push(5'd11, 32'h1111_1111);
            if (c == 5) exp_push(5'd12, 32'h1212_1212);
            if (c == 4) iMduValid = 1'b1;
            tick();
        end
        iAluValid = 1'b0;
        iMduValid = 1'b0;
        tick();
        chk("full_pending_clr", oMduPending, 32'd0);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4: cycles a queued MDU result may be bypassed by ALU writebacks before its grant is forced (range 1..15).
REQ-002 iCLK  in  1  single clock; all state updates on posedge.
REQ-003 iRST  in  1  reset, asynchronous, active-high.
REQ-004 iAluValid  in  1  ALU pipeline writeback request.
REQ-005 iAluRd  in  5  ALU destination register.
REQ-006 iAluData  in  32  ALU result.
REQ-007 oAluStall  out  1  ALU request not accepted this cycle; ALU holds request.
REQ-008 iMduValid  in  1  multi-cycle unit (mul/div/load) result valid.
REQ-009 iMduRd  in  5  MDU destination register.
REQ-010 iMduData  in  32  MDU result.
REQ-011 oMduReady  out  1  MDU result accepted when iMduValid && oMduReady.
REQ-012 oRegWrite  out  1  register-file write enable (registered).
REQ-013 oWriteRegister  out  5  register-file write address (registered).
REQ-014 oWriteData  out  32  register-file write data (registered).
REQ-015 oMduPending  out  32  bit n set while an MDU write to xn is queued and not yet issued.

Function
REQ-016 MDU results SHALL enter a 2-entry FIFO; oMduReady = !iRST && count<2.
REQ-017 Push and pop in one cycle SHALL leave count unchanged; order SHALL be strictly FIFO.
REQ-018 Each cycle exactly one source SHALL be granted the write port: ALU, FIFO head, or none.
REQ-019 State NORMAL: ALU granted if iAluValid; else FIFO head granted if count>0.
REQ-020 State FORCE: FIFO head granted; oAluStall = iAluValid; ALU not accepted.
REQ-021 In NORMAL, oAluStall SHALL be 0.
REQ-022 Wait counter (4 bits): cleared on FIFO-head grant or when FIFO empty; else increments while head bypassed; saturates at MAX_WAIT.
REQ-023 Transition NORMAL->FORCE when counter reaches MAX_WAIT and count>0; FORCE->NORMAL after the forced grant (one cycle in FORCE per forced entry).
REQ-024 Granted request SHALL appear on oRegWrite/oWriteRegister/oWriteData at the next posedge (latency 1); cycles with no grant drive oRegWrite=0, address/data hold.
REQ-025 A granted request with rd=0 SHALL be consumed (FIFO popped or ALU accepted) but drive oRegWrite=0.
REQ-026 An MDU value pushed this cycle SHALL NOT be granted in the same cycle (no FIFO bypass).
REQ-027 oMduPending SHALL be the OR of one-hot(rd) over valid FIFO entries, rd=0 excluded, updated combinationally from FIFO state.
REQ-028 Two queued entries to the same rd SHALL both be issued in order; pending bit clears only when neither remains.
REQ-029 iAluRd equal to a pending rd SHALL NOT be blocked by the arbiter (ordering hazards are the pipeline's concern via oMduPending).

Reset
REQ-030 While iRST=1: oRegWrite=0, oWriteRegister=0, oWriteData=0, FIFO empty, counter=0, state=NORMAL, oMduReady=0, oAluStall=0, oMduPending=0.
REQ-031 Reset asserted mid-operation SHALL discard queued MDU entries with no write issued; first grant possible in the first cycle after iRST deasserts.

Verification
REQ-032 ALU only: iAluValid=1, rd=5, data=0xDEADBEEF -> next cycle oRegWrite=1, x5, 0xDEADBEEF; oAluStall=0.
REQ-033 MDU only: push rd=7, 0x12345678 with ALU idle -> write of x7 two cycles after push; oMduPending[7]=1 in between, then 0.
REQ-034 Starvation: MAX_WAIT=4, MDU entry queued, ALU valid continuously -> 4 ALU writes, then oAluStall=1 for one cycle and MDU write issues, then ALU resumes.
REQ-035 FIFO full: two MDU pushes while ALU busy -> oMduReady=0; third value held by MDU until a pop; all three write in order.
REQ-036 x0 and reset: ALU rd=0 -> consumed, oRegWrite=0; iRST pulse with 2 queued entries -> no writes issued, oMduPending=0, counter=0.
